led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 2, number of LED channels (1..16).
REQ-002 SHALL have parameter PRESCALE, default 50000, clk cycles per tick (>=2).
REQ-003 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width (4..12).
REQ-004 SHALL have parameter DEF_MODE, default 2'b10 (BLINK), mode of every channel after reset.
REQ-005 SHALL have parameter DEF_PERIOD, default 16'd500, period in ticks of every channel after reset.
REQ-006 SHALL have port clk, input, 1, single clock for all logic.
REQ-007 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_cfg_valid, input, 1, config write request.
REQ-009 SHALL have port o_cfg_ready, output, 1, block can accept a config write.
REQ-010 SHALL have port i_cfg_ch, input, 4, target channel index.
REQ-011 SHALL have port i_cfg_mode, input, 2, 00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
REQ-012 SHALL have port i_cfg_period, input, 16, period in ticks; 0 is treated as 1.
REQ-013 SHALL have port o_cfg_err, output, 1, one-cycle pulse when a write targets i_cfg_ch >= N_LED.
REQ-014 SHALL have port o_tick, output, 1, one-cycle pulse per prescaler tick.
REQ-015 SHALL have port o_LED, output, N_LED, LED drive, active-high.

Function
REQ-016 SHALL run a prescaler counter 0..PRESCALE-1 that wraps to 0; o_tick SHALL be high exactly in the cycle the counter equals PRESCALE-1.
REQ-017 SHALL run a free-running PWM_BITS-wide PWM counter, incremented every clk, wrapping from all-ones to 0.
REQ-018 SHALL accept a write on a clk edge where i_cfg_valid && o_cfg_ready; i_cfg_valid may stay high without creating a duplicate write while o_cfg_ready is low.
REQ-019 SHALL drive o_cfg_ready low for exactly one cycle after each accepted write, then high again.
REQ-020 SHALL make an accepted write to a valid channel take effect in the cycle after acceptance: mode and period registers updated, tick counter cleared, blink state 0, duty 0, breathe direction up.
REQ-021 SHALL ignore writes with i_cfg_ch >= N_LED and pulse o_cfg_err in the cycle after acceptance; no channel state changes.
REQ-022 SHALL keep a 16-bit tick counter per channel, incremented on o_tick; when it equals max(period,1)-1 on a tick it SHALL wrap to 0 and raise a one-tick channel event.
REQ-023 SHALL hold o_LED[i]=0 in OFF and o_LED[i]=1 in ON, independent of ticks.
REQ-024 SHALL, in BLINK, toggle the channel blink state on each channel event and drive o_LED[i] = blink state.
REQ-025 SHALL, in BREATHE, step duty by 1 per channel event: up until all-ones, then down until 0, then up again (triangle; direction reverses on the event that reaches the endpoint).
REQ-026 SHALL, in BREATHE, drive o_LED[i] = (PWM counter < duty), so duty 0 gives constant 0 and all-ones gives 1 for all but one count.
REQ-027 SHALL register o_LED (one clk latency from the internal state/comparison).
REQ-028 SHALL, when a write coincides with a channel event on the same channel, apply the write and discard the event.
REQ-029 SHALL let channels not targeted by a write continue undisturbed.

Reset
REQ-030 SHALL, while resetN=0, clear the prescaler, PWM counter, all tick counters, blink states and duties, and set directions up, modes DEF_MODE, periods DEF_PERIOD.
REQ-031 SHALL, while resetN=0, drive o_LED=0, o_tick=0, o_cfg_err=0, o_cfg_ready=0; o_cfg_ready SHALL go high on the first clk edge after deassertion.
REQ-032 SHALL restart from the reset state on assertion mid-operation, including abandoning any in-flight write.

Verification
REQ-033 SHALL cover PRESCALE=4, default BLINK, DEF_PERIOD=3 -> o_tick every 4 clks; o_LED[0] toggles every 12 clks, first rising edge 13 clks after reset release.
REQ-034 SHALL cover a write of ch=1, mode=ON, then ch=1, mode=OFF -> o_LED[1] becomes 1 two cycles after the first acceptance, 0 two cycles after the second; o_cfg_ready low one cycle after each.
REQ-035 SHALL cover a write of ch=5 with N_LED=2 -> o_cfg_err pulses once, o_LED unchanged.
REQ-036 SHALL cover PWM_BITS=4, BREATHE, period=1 -> duty sequence 0,1..15,14..0,1 per tick; high-time per 16-clk PWM frame equals duty.
REQ-037 SHALL cover a write with period=0 -> behaves as period=1 (event every tick).
REQ-038 SHALL cover resetN pulled low mid-blink with o_LED=1 -> o_LED=0 immediately (async), default pattern resumes after release.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// led_pattern_ctrl: per-channel OFF/ON/BLINK/BREATHE LED driver sharing one
// prescaler tick and one PWM counter, configured through a valid/ready write port.
module led_pattern_ctrl #(
  parameter int          N_LED      = 2,
  parameter int          PRESCALE   = 50000,
  parameter int          PWM_BITS   = 8,
  parameter logic [1:0]  DEF_MODE   = 2'b10,
  parameter logic [15:0] DEF_PERIOD = 16'd500
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [3:0]       i_cfg_ch,
  input  logic [1:0]       i_cfg_mode,
  input  logic [15:0]      i_cfg_period,
  output logic             o_cfg_err,
  output logic             o_tick,
  output logic [N_LED-1:0] o_LED
);

  localparam int                  PRE_W        = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0]    PRE_LAST     = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_TOP     = DUTY_MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE     = PWM_BITS'(1);
  localparam logic [1:0]          MODE_OFF     = 2'b00;
  localparam logic [1:0]          MODE_ON      = 2'b01;
  localparam logic [1:0]          MODE_BLINK   = 2'b10;
  localparam logic [1:0]          MODE_BREATHE = 2'b11;

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                cfg_ready;
  logic                accept;
  logic                ch_valid;

  logic [1:0]          mode   [N_LED];
  logic [15:0]         period [N_LED];
  logic [15:0]         tcnt   [N_LED];
  logic [PWM_BITS-1:0] duty   [N_LED];
  logic [N_LED-1:0]    blink;
  logic [N_LED-1:0]    dir_down;
  logic [N_LED-1:0]    wr_hit;
  logic [N_LED-1:0]    ev_hit;
  logic [N_LED-1:0]    led_next;

  assign o_tick      = (pre_cnt == PRE_LAST);
  assign o_cfg_ready = cfg_ready;
  assign accept      = i_cfg_valid && cfg_ready;
  assign ch_valid    = ({1'b0, i_cfg_ch} < 5'(N_LED));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Ready drops for the single cycle following every accepted write.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cfg_ready <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      o_cfg_err <= accept && !ch_valid;
    end
  end

  always_comb begin
    wr_hit   = '0;
    ev_hit   = '0;
    led_next = '0;
    for (int i = 0; i < N_LED; i++) begin
      wr_hit[i] = accept && (i_cfg_ch == 4'(i));
      // A period of 0 runs like 1, so both wrap from count 0.
      ev_hit[i] = o_tick &&
                  (tcnt[i] == ((period[i] == 16'd0) ? 16'd0 : period[i] - 16'd1));
      case (mode[i])
        MODE_OFF:   led_next[i] = 1'b0;
        MODE_ON:    led_next[i] = 1'b1;
        MODE_BLINK: led_next[i] = blink[i];
        default:    led_next[i] = (pwm_cnt < duty[i]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < N_LED; i++) begin
        mode[i]   <= DEF_MODE;
        period[i] <= DEF_PERIOD;
        tcnt[i]   <= '0;
        duty[i]   <= '0;
      end
      blink    <= '0;
      dir_down <= '0;
      o_LED    <= '0;
    end else begin
      o_LED <= led_next;
      for (int i = 0; i < N_LED; i++) begin
        // A write wins over an event landing on the same edge.
        if (wr_hit[i]) begin
          mode[i]     <= i_cfg_mode;
          period[i]   <= i_cfg_period;
          tcnt[i]     <= '0;
          duty[i]     <= '0;
          blink[i]    <= 1'b0;
          dir_down[i] <= 1'b0;
        end else if (ev_hit[i]) begin
          tcnt[i] <= '0;
          if (mode[i] == MODE_BLINK) begin
            blink[i] <= ~blink[i];
          end
          if (mode[i] == MODE_BREATHE) begin
            if (!dir_down[i]) begin
              duty[i] <= duty[i] + DUTY_ONE;
              if (duty[i] == DUTY_TOP) dir_down[i] <= 1'b1;
            end else begin
              duty[i] <= duty[i] - DUTY_ONE;
              if (duty[i] == DUTY_ONE) dir_down[i] <= 1'b0;
            end
          end
        end else if (o_tick) begin
          tcnt[i] <= tcnt[i] + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// Bench for led_pattern_ctrl: closed-form pattern model per channel, a table of
// config writes with a ready/err scoreboard, and reset corner sequences.
module tb_led_pattern_ctrl;

  localparam int         N_LED     = 2;
  localparam int         PRESCALE  = 4;
  localparam int         PWM_BITS  = 4;
  localparam int         DMAX      = 15;
  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_BREATHE = 2'b11;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             i_cfg_valid = 1'b0;
  logic [3:0]       i_cfg_ch = '0;
  logic [1:0]       i_cfg_mode = '0;
  logic [15:0]      i_cfg_period = '0;
  logic             o_cfg_ready;
  logic             o_cfg_err;
  logic             o_tick;
  logic [N_LED-1:0] o_LED;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  typedef struct { logic [1:0] mode; int period; int acc; } cfg_t;
  typedef struct { int acc; logic err; } exp_t;
  typedef struct {
    logic [3:0]  ch;
    logic [1:0]  mode;
    logic [15:0] period;
    int          hold;
    int          settle;
    logic        exp_err;
  } vec_t;

  cfg_t cur  [N_LED];
  cfg_t prev [N_LED];
  exp_t sb   [$];

  led_pattern_ctrl #(
    .N_LED(N_LED), .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS),
    .DEF_MODE(M_BLINK), .DEF_PERIOD(16'd3)
  ) dut (
    .clk(clk), .resetN(resetN),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_ch(i_cfg_ch), .i_cfg_mode(i_cfg_mode), .i_cfg_period(i_cfg_period),
    .o_cfg_err(o_cfg_err), .o_tick(o_tick), .o_LED(o_LED)
  );

  always #5 clk = ~clk;

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) k <= 0;
    else         k <= k + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected LED of channel ch from the state reached after edge kk.
  function automatic logic model_led(input int ch, input int kk);
    cfg_t c;
    int   p, t, n, m, d;
    c = (kk >= cur[ch].acc) ? cur[ch] : prev[ch];
    p = (c.period == 0) ? 1 : c.period;
    t = kk / PRESCALE - c.acc / PRESCALE;
    n = t / p;
    case (c.mode)
      M_OFF:   return 1'b0;
      M_ON:    return 1'b1;
      M_BLINK: return n[0];
      default: begin
        m = n % (2 * DMAX);
        d = (m <= DMAX) ? m : 2 * DMAX - m;
        return (kk % (DMAX + 1)) < d;
      end
    endcase
  endfunction

  task automatic model_defaults();
    for (int c = 0; c < N_LED; c++) begin
      cur[c]  = '{M_BLINK, 3, 0};
      prev[c] = cur[c];
    end
    sb.delete();
  endtask

  always @(negedge clk) begin
    logic [N_LED-1:0] exp_led;
    logic             exp_rdy;
    logic             exp_err;
    exp_led = '0;
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    if (resetN && k > 0) begin
      for (int c = 0; c < N_LED; c++) exp_led[c] = model_led(c, k - 1);
      exp_rdy = 1'b1;
      if (sb.size() > 0 && sb[0].acc == k) begin
        exp_rdy = 1'b0;
        exp_err = sb[0].err;
        void'(sb.pop_front());
      end
    end
    check("led", 32'(o_LED), 32'(exp_led));
    check("tick", 32'(o_tick), 32'(resetN && (k % PRESCALE == PRESCALE - 1)));
    check("cfg_ready", 32'(o_cfg_ready), 32'(exp_rdy));
    check("cfg_err", 32'(o_cfg_err), 32'(exp_err));
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic do_write(input vec_t v);
    int   waited;
    exp_t e;
    waited       = 0;
    i_cfg_valid  = 1'b1;
    i_cfg_ch     = v.ch;
    i_cfg_mode   = v.mode;
    i_cfg_period = v.period;
    while (!o_cfg_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!o_cfg_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL write_accept: ready %b expected 1 within 8 cycles", o_cfg_ready);
      i_cfg_valid = 1'b0;
      return;
    end
    e.acc = k + 1;
    e.err = v.exp_err;
    sb.push_back(e);
    if (v.ch < N_LED) begin
      prev[v.ch] = cur[v.ch];
      cur[v.ch]  = '{v.mode, int'(v.period), k + 1};
    end
    repeat (v.hold + 1) @(negedge clk);
    i_cfg_valid = 1'b0;
    repeat (v.settle) @(negedge clk);
  endtask

  initial begin
    vec_t tbl [12];
    vec_t hv;
    int   guard;

    tbl[0]  = '{4'd1,  M_ON,      16'd5, 0, 6,   1'b0};
    tbl[1]  = '{4'd1,  M_OFF,     16'd5, 0, 6,   1'b0};
    tbl[2]  = '{4'd5,  M_ON,      16'd1, 0, 4,   1'b1};
    tbl[3]  = '{4'd15, M_BLINK,   16'd2, 1, 4,   1'b1};
    tbl[4]  = '{4'd0,  M_ON,      16'd1, 1, 0,   1'b0};
    tbl[5]  = '{4'd1,  M_ON,      16'd9, 0, 4,   1'b0};
    tbl[6]  = '{4'd0,  M_BLINK,   16'd0, 0, 30,  1'b0};
    tbl[7]  = '{4'd1,  M_BREATHE, 16'd1, 0, 130, 1'b0};
    tbl[8]  = '{4'd0,  M_BREATHE, 16'd2, 0, 10,  1'b0};
    tbl[9]  = '{4'd0,  M_BLINK,   16'd2, 0, 0,   1'b0};
    tbl[10] = '{4'd0,  M_BLINK,   16'd1, 0, 40,  1'b0};
    tbl[11] = '{4'd1,  M_OFF,     16'd0, 1, 10,  1'b0};

    model_defaults();
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetN = 1'b1;

    // Default blink pattern from reset, then reset while the LED is lit.
    repeat (40) @(negedge clk);
    guard = 0;
    while (!o_LED[0] && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("blink_high_before_reset", 32'(o_LED[0]), 32'd1);
    @(posedge clk);
    #2 resetN = 1'b0;
    model_defaults();
    #1 check("async_reset_led", 32'(o_LED), 32'd0);
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    repeat (30) @(negedge clk);

    for (int i = 0; i < 12; i++) do_write(tbl[i]);

    // Write landing on a tick edge while ch1 breathes with an event every tick.
    hv = '{4'd1, M_BREATHE, 16'd1, 0, 20, 1'b0};
    do_write(hv);
    while (k % PRESCALE != PRESCALE - 1) @(negedge clk);
    hv = '{4'd1, M_BLINK, 16'd1, 0, 30, 1'b0};
    do_write(hv);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
